// File: rtl/reg_bank_sb.sv
// Register bank with per-register pending (scoreboard) bits, two registered read ports and a PC.
// Reads of a pending register stall until the clearing write, which is forwarded on that same edge.
module reg_bank_sb #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 4,
  parameter int              PC_IDX   = 15,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                   trigger,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   lock_en,
  input  logic [ADDR_W-1:0]      lock_addr,
  input  logic                   ra_req,
  input  logic [ADDR_W-1:0]      ra_addr,
  output logic [DATA_W-1:0]      ra_data,
  output logic                   ra_ack,
  input  logic                   rb_req,
  input  logic [ADDR_W-1:0]      rb_addr,
  output logic [DATA_W-1:0]      rb_data,
  output logic                   rb_ack,
  input  logic                   pc_inc,
  output logic [DATA_W-1:0]      pc_out,
  output logic [2**ADDR_W-1:0]   pend
);

  localparam int                NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] ra_data_q, ra_data_d, rb_data_q, rb_data_d;
  logic              ra_ack_q, ra_ack_d, rb_ack_q, rb_ack_d;
  logic              ra_hit, rb_hit;

  assign ra_hit = wr_en && (wr_addr == ra_addr);
  assign rb_hit = wr_en && (wr_addr == rb_addr);

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    // Lock is applied after the write so a same-index lock keeps the register pending.
    if (lock_en) begin
      pend_d[lock_addr] = 1'b1;
    end
    if (!(wr_en && (wr_addr == PC_A)) && pc_inc) begin
      regs_d[PC_IDX] = regs_q[PC_IDX] + DATA_W'(4);
    end
  end

  always_comb begin
    ra_ack_d  = 1'b0;
    ra_data_d = ra_data_q;
    rb_ack_d  = 1'b0;
    rb_data_d = rb_data_q;
    if (ra_req && (!pend_q[ra_addr] || ra_hit)) begin
      ra_ack_d  = 1'b1;
      ra_data_d = ra_hit ? wr_data : regs_q[ra_addr];
    end
    if (rb_req && (!pend_q[rb_addr] || rb_hit)) begin
      rb_ack_d  = 1'b1;
      rb_data_d = rb_hit ? wr_data : regs_q[rb_addr];
    end
  end

  always_ff @(posedge trigger) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == PC_IDX) ? RESET_PC : '0;
      end
      pend_q    <= '0;
      ra_data_q <= '0;
      ra_ack_q  <= 1'b0;
      rb_data_q <= '0;
      rb_ack_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      pend_q    <= pend_d;
      ra_data_q <= ra_data_d;
      ra_ack_q  <= ra_ack_d;
      rb_data_q <= rb_data_d;
      rb_ack_q  <= rb_ack_d;
    end
  end

  assign ra_data = ra_data_q;
  assign ra_ack  = ra_ack_q;
  assign rb_data = rb_data_q;
  assign rb_ack  = rb_ack_q;
  assign pc_out  = regs_q[PC_IDX];
  assign pend    = pend_q;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed bench for reg_bank_sb; two instances differ only in RESET_PC (0x100 and 0xFFFFFFFC).
module tb_reg_bank_sb;

  logic        trigger = 1'b0;
  logic        rst_n;
  logic        wr_en, lock_en, ra_req, rb_req, pc_inc;
  logic [3:0]  wr_addr, lock_addr, ra_addr, rb_addr;
  logic [31:0] wr_data;

  logic [31:0] a_ra_data, a_rb_data, a_pc_out;
  logic        a_ra_ack, a_rb_ack;
  logic [15:0] a_pend;
  logic [31:0] b_ra_data, b_rb_data, b_pc_out;
  logic        b_ra_ack, b_rb_ack;
  logic [15:0] b_pend;

  int total = 0;
  int bad   = 0;

  always #5 trigger = ~trigger;

  reg_bank_sb #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .RESET_PC(32'h0000_0100)) dut_a (
    .trigger(trigger), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .ra_req(ra_req), .ra_addr(ra_addr), .ra_data(a_ra_data), .ra_ack(a_ra_ack),
    .rb_req(rb_req), .rb_addr(rb_addr), .rb_data(a_rb_data), .rb_ack(a_rb_ack),
    .pc_inc(pc_inc), .pc_out(a_pc_out), .pend(a_pend)
  );

  reg_bank_sb #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .trigger(trigger), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .ra_req(ra_req), .ra_addr(ra_addr), .ra_data(b_ra_data), .ra_ack(b_ra_ack),
    .rb_req(rb_req), .rb_addr(rb_addr), .rb_data(b_rb_data), .rb_ack(b_rb_ack),
    .pc_inc(pc_inc), .pc_out(b_pc_out), .pend(b_pend)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge trigger);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; lock_en = 0; ra_req = 0; rb_req = 0; pc_inc = 0;
    wr_addr = 0; lock_addr = 0; ra_addr = 0; rb_addr = 0; wr_data = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick();
    check("rst_pc_a",   a_pc_out, 32'h100);
    check("rst_pc_b",   b_pc_out, 32'hFFFF_FFFC);
    check("rst_pend",   {16'h0, a_pend}, 32'h0);
    check("rst_ra_ack", {31'h0, a_ra_ack}, 32'h0);
    check("rst_rb_ack", {31'h0, a_rb_ack}, 32'h0);
    check("rst_ra_dat", a_ra_data, 32'h0);

    // Plain read of PC after reset
    rst_n = 1; ra_req = 1; ra_addr = 15;
    tick();
    check("pcrd_data", a_ra_data, 32'h100);
    check("pcrd_ack",  {31'h0, a_ra_ack}, 32'h1);
    check("pcrd_pc",   a_pc_out, 32'h100);

    // PC wrap, then write beats pc_inc
    idle(); pc_inc = 1;
    tick();
    check("wrap_pc_b", b_pc_out, 32'h0);
    check("inc_pc_a",  a_pc_out, 32'h104);
    check("noreq_ack", {31'h0, a_ra_ack}, 32'h0);
    check("noreq_hold", a_ra_data, 32'h100);
    wr_en = 1; wr_addr = 15; wr_data = 32'h2000;
    tick();
    check("prio_pc_b", b_pc_out, 32'h2000);
    check("prio_pc_a", a_pc_out, 32'h2000);

    // Read PC while pc_inc: pre-edge value, no bypass of the increment
    idle(); pc_inc = 1; ra_req = 1; ra_addr = 15;
    tick();
    check("pcinc_rd",  a_ra_data, 32'h2000);
    check("pcinc_pc",  a_pc_out, 32'h2004);

    // Write r3, then dual read, held for back-to-back
    idle(); wr_en = 1; wr_addr = 3; wr_data = 32'hDEAD_BEEF;
    tick();
    idle(); ra_req = 1; rb_req = 1; ra_addr = 3; rb_addr = 3;
    tick();
    check("dual_ra", a_ra_data, 32'hDEAD_BEEF);
    check("dual_rb", a_rb_data, 32'hDEAD_BEEF);
    check("dual_ack", {30'h0, a_ra_ack, a_rb_ack}, 32'h3);
    tick();
    check("b2b_ack", {30'h0, a_ra_ack, a_rb_ack}, 32'h3);
    idle();
    tick();
    check("idle_ack", {30'h0, a_ra_ack, a_rb_ack}, 32'h0);
    check("idle_hold", a_rb_data, 32'hDEAD_BEEF);

    // Lock r5, stall three edges, then clearing write is forwarded
    lock_en = 1; lock_addr = 5;
    tick();
    check("lock5_pend", {31'h0, a_pend[5]}, 32'h1);
    idle(); ra_req = 1; ra_addr = 5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ack",  {31'h0, a_ra_ack}, 32'h0);
      check("stall_pend", {31'h0, a_pend[5]}, 32'h1);
      check("stall_hold", a_ra_data, 32'hDEAD_BEEF);
    end
    // Relocking a stalled index keeps the read stalled
    lock_en = 1; lock_addr = 5;
    tick();
    check("relock_ack", {31'h0, a_ra_ack}, 32'h0);
    lock_en = 0; wr_en = 1; wr_addr = 5; wr_data = 32'h1234;
    tick();
    check("clr_ack",  {31'h0, a_ra_ack}, 32'h1);
    check("clr_data", a_ra_data, 32'h1234);
    check("clr_pend", {31'h0, a_pend[5]}, 32'h0);

    // Lock and write on the same edge: producer wins, later read stalls
    idle(); lock_en = 1; lock_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 32'h55;
    tick();
    check("lw_pend", {31'h0, a_pend[7]}, 32'h1);
    idle(); rb_req = 1; rb_addr = 7;
    tick();
    check("lw_stall", {31'h0, a_rb_ack}, 32'h0);
    check("lw_hold",  a_rb_data, 32'hDEAD_BEEF);

    // Mid-stall reset, with a same-edge write to PC that must be ignored
    idle(); lock_en = 1; lock_addr = 2;
    tick();
    idle(); ra_req = 1; ra_addr = 2;
    tick();
    check("ms_stall", {31'h0, a_ra_ack}, 32'h0);
    rst_n = 0; wr_en = 1; wr_addr = 15; wr_data = 32'h999;
    tick();
    check("ms_ack",  {31'h0, a_ra_ack}, 32'h0);
    check("ms_pend", {16'h0, a_pend}, 32'h0);
    check("ms_pend_b", {16'h0, b_pend}, 32'h0);
    check("ms_pc",   a_pc_out, 32'h100);
    rst_n = 1; wr_en = 0;
    tick();
    check("rel_ack",  {31'h0, a_ra_ack}, 32'h1);
    check("rel_data", a_ra_data, 32'h0);
    check("rel_ack_b", {31'h0, b_ra_ack}, 32'h1);
    check("rel_pc_b", b_pc_out, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
